rtc_bus_scheduler: RTL and testbench
====================================

// Module: rtc_bus_scheduler
// PURPOSE
//  Sole owner of the shared RTC parallel bus (a_d, cs, rd, wr). Arbitrates three transaction FSMs
//  (init, write, read) and holds each one's do_it level for a fixed transaction length.
//  Muxes the granted FSM's bus controls to the pins and issues periodic time-refresh reads.
//  Sits between the top-level controller and the init/write/read RTC FSMs.
// PARAMETERS
//  INIT_CYCLES    352     cycles do_it_init stays high per init transaction
//  WRITE_CYCLES   352     cycles do_it_escribir stays high per write transaction
//  READ_CYCLES    352     cycles do_it_leer stays high per read transaction (counter 0..351 in read FSM)
//  GAP_CYCLES     4       bus-idle turnaround cycles after every transaction (>=1)
//  REFRESH_PERIOD 100000  cycles between automatic read requests while read_en=1 (>=2)
//  CNT_W          17      width of both counters; must hold max(REFRESH_PERIOD, *_CYCLES)-1
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-low reset
//  req_init       in   1  init request (level or pulse, latched)
//  req_write      in   1  write request (level or pulse, latched)
//  read_en        in   1  enables automatic periodic reads
//  init_a_d/init_cs/init_rd/init_wr  in 1 each  bus controls from init FSM
//  wr_a_d/wr_cs/wr_rd/wr_wr          in 1 each  bus controls from write FSM
//  rd_a_d/rd_cs/rd_rd/rd_wr          in 1 each  bus controls from read FSM
//  a_d, cs, rd, wr out  1 each  RTC bus controls (idle value 1 on all four)
//  do_it_init, do_it_escribir, do_it_leer  out 1 each  start/hold level to the respective FSM
//  busy           out  1  1 in any state except IDLE
//  grant          out  2  00 none, 01 init, 10 write, 11 read
//  done           out  1  one-cycle pulse in first GAP cycle after any transaction
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, all counters and pending flags 0, do_it_*=0, grant=00, busy=0,
//    done=0, a_d=cs=rd=wr=1. Asynchronous: an in-progress transaction is aborted immediately.
//  - Pending flags p_init, p_write, p_read: set on any edge where req_init / req_write /
//    refresh tick is high. Cleared on the edge that grants that class. A request while its class
//    is active sets the flag again, giving one further transaction.
//  - Refresh timer: counts 0..REFRESH_PERIOD-1 while read_en=1 and wraps. tick=1 at terminal count.
//    read_en=0 holds timer at 0 and clears p_read. An active READ is not aborted.
//  - FSM states: IDLE, INIT, WRITE, READ, GAP.
//    IDLE: evaluates (p_x | raw request) with priority init > write > read.
//      On the next edge, moves to the winning state and clears its pending flag (latency 1 cycle).
//    INIT/WRITE/READ: the matching do_it_* = 1 and grant is set. Transaction counter runs 0..N-1.
//      At count N-1 the next edge goes to GAP. do_it_* is high exactly N cycles.
//    GAP: do_it_*=0, bus idle. done=1 in the first GAP cycle only.
//      After GAP_CYCLES cycles, returns to IDLE; a pending request is granted on the following edge.
//  - No preemption: a higher-priority request during a transaction waits for GAP+IDLE.
//  - Bus mux (combinational from registered state): pins = granted FSM inputs; all 1 in IDLE/GAP.
//  - Simultaneous req_init+req_write+tick in IDLE: init served first, then write, then read.
//    Each transaction is followed by GAP.
//  - do_it_*, grant, busy, done are decoded from registered state/counter: glitch-free, no comb path from req_*.
// TESTING
//  1 reset low mid-READ (count 100) -> same cycle do_it_leer=0, a_d=cs=rd=wr=1, grant=00; after
//    release, IDLE with no spurious grant.
//  2 req_write pulse 1 cycle in IDLE -> next edge grant=10, do_it_escribir high exactly 352 cycles,
//    done pulse at GAP start, IDLE after 4 GAP cycles.
//  3 req_init, req_write, read_en tick asserted same edge -> order INIT, WRITE, READ,
//    each 352 cycles + 4-cycle GAP, three done pulses.
//  4 read_en=1, REFRESH_PERIOD=1000, no other req -> do_it_leer rises every 1000 cycles.
//    Then read_en=0 mid-READ -> read completes, no further reads.
//  5 req_init pulse during READ at count 50 -> no preemption; INIT granted 1 cycle after GAP ends.
//  6 mux check in WRITE: toggle wr_cs/rd_cs/init_cs -> cs follows wr_cs only; in GAP, cs stays 1.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// rtl/rtc_bus_scheduler.sv - RTC parallel bus owner: arbitrates init/write/read FSMs, periodic refresh reads
module rtc_bus_scheduler #(
  parameter int INIT_CYCLES    = 352,
  parameter int WRITE_CYCLES   = 352,
  parameter int READ_CYCLES    = 352,
  parameter int GAP_CYCLES     = 4,
  parameter int REFRESH_PERIOD = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_init,
  input  logic       req_write,
  input  logic       read_en,
  input  logic       init_a_d,
  input  logic       init_cs,
  input  logic       init_rd,
  input  logic       init_wr,
  input  logic       wr_a_d,
  input  logic       wr_cs,
  input  logic       wr_rd,
  input  logic       wr_wr,
  input  logic       rd_a_d,
  input  logic       rd_cs,
  input  logic       rd_rd,
  input  logic       rd_wr,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       do_it_init,
  output logic       do_it_escribir,
  output logic       do_it_leer,
  output logic       busy,
  output logic [1:0] grant,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] tmr;
  logic             tick;
  logic             p_init, p_write, p_read;
  logic             go_init, go_write, go_read;

  assign tick = read_en && (tmr == REF_LAST);

  // Refresh timer: free-runs while reads are enabled, parked at zero otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr <= '0;
    end else if (!read_en || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + CNT_ONE;
    end
  end

  // Grant decision in IDLE: latched or raw request, init > write > read
  always_comb begin
    go_init  = 1'b0;
    go_write = 1'b0;
    go_read  = 1'b0;
    if (state == S_IDLE) begin
      if (p_init || req_init) begin
        go_init = 1'b1;
      end else if (p_write || req_write) begin
        go_write = 1'b1;
      end else if (read_en && (p_read || tick)) begin
        go_read = 1'b1;
      end
    end
  end

  // Pending flags: the grant edge consumes a request, any other request edge sets it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_init  <= 1'b0;
      p_write <= 1'b0;
      p_read  <= 1'b0;
    end else begin
      p_init  <= go_init  ? 1'b0 : (p_init  || req_init);
      p_write <= go_write ? 1'b0 : (p_write || req_write);
      p_read  <= (!read_en || go_read) ? 1'b0 : (p_read || tick);
    end
  end

  // Next state and transaction/gap counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (go_init) begin
          state_nx = S_INIT;
        end else if (go_write) begin
          state_nx = S_WRITE;
        end else if (go_read) begin
          state_nx = S_READ;
        end
      end
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_WRITE: begin
        if (cnt == WRITE_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_READ: begin
        if (cnt == READ_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register; reset aborts any transaction immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs decoded from registered state only; bus pins idle high outside a transaction
  always_comb begin
    a_d            = 1'b1;
    cs             = 1'b1;
    rd             = 1'b1;
    wr             = 1'b1;
    do_it_init     = 1'b0;
    do_it_escribir = 1'b0;
    do_it_leer     = 1'b0;
    grant          = 2'b00;
    busy           = (state != S_IDLE);
    done           = (state == S_GAP) && (cnt == '0);
    case (state)
      S_INIT: begin
        a_d        = init_a_d;
        cs         = init_cs;
        rd         = init_rd;
        wr         = init_wr;
        do_it_init = 1'b1;
        grant      = 2'b01;
      end
      S_WRITE: begin
        a_d            = wr_a_d;
        cs             = wr_cs;
        rd             = wr_rd;
        wr             = wr_wr;
        do_it_escribir = 1'b1;
        grant          = 2'b10;
      end
      S_READ: begin
        a_d        = rd_a_d;
        cs         = rd_cs;
        rd         = rd_rd;
        wr         = rd_wr;
        do_it_leer = 1'b1;
        grant      = 2'b11;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb/tb_rtc_bus_scheduler.sv - randomized and directed bench for rtc_bus_scheduler with schedule model
module tb_rtc_bus_scheduler;

  localparam int NI = 352;
  localparam int NW = 352;
  localparam int NR = 352;
  localparam int G  = 4;
  localparam int P  = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_init = 1'b0, req_write = 1'b0, read_en = 1'b0;
  logic       init_a_d = 1'b1, init_cs = 1'b1, init_rd = 1'b1, init_wr = 1'b1;
  logic       wr_a_d = 1'b1, wr_cs = 1'b1, wr_rd = 1'b1, wr_wr = 1'b1;
  logic       rd_a_d = 1'b1, rd_cs = 1'b1, rd_rd = 1'b1, rd_wr = 1'b1;
  logic       a_d, cs, rd, wr;
  logic       do_it_init, do_it_escribir, do_it_leer, busy, done;
  logic [1:0] grant;

  rtc_bus_scheduler #(
    .INIT_CYCLES(NI), .WRITE_CYCLES(NW), .READ_CYCLES(NR),
    .GAP_CYCLES(G), .REFRESH_PERIOD(P), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset),
    .req_init(req_init), .req_write(req_write), .read_en(read_en),
    .init_a_d(init_a_d), .init_cs(init_cs), .init_rd(init_rd), .init_wr(init_wr),
    .wr_a_d(wr_a_d), .wr_cs(wr_cs), .wr_rd(wr_rd), .wr_wr(wr_wr),
    .rd_a_d(rd_a_d), .rd_cs(rd_cs), .rd_rd(rd_rd), .rd_wr(rd_wr),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .do_it_init(do_it_init), .do_it_escribir(do_it_escribir), .do_it_leer(do_it_leer),
    .busy(busy), .grant(grant), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cycle_no, act, exp);
    end
  endtask

  // Schedule model: which class holds the bus and how long since it was granted
  int m_cur = 0;
  int m_t = 0;
  int m_run = 0;
  bit m_pi = 0, m_pw = 0, m_pr = 0;

  function automatic int len_of(input int c);
    if (c == 1) return NI;
    if (c == 2) return NW;
    return NR;
  endfunction

  always @(posedge clk) begin
    bit tk;
    int g;
    if (!reset) begin
      m_cur = 0; m_t = 0; m_run = 0;
      m_pi = 0; m_pw = 0; m_pr = 0;
    end else begin
      tk = read_en && ((m_run % P) == P - 1);
      g = 0;
      if (m_cur == 0) begin
        if (m_pi || req_init) g = 1;
        else if (m_pw || req_write) g = 2;
        else if (read_en && (m_pr || tk)) g = 3;
        if (g != 0) begin
          m_cur = g;
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t == len_of(m_cur) + G) m_cur = 0;
      end
      m_pi = (g == 1) ? 1'b0 : (m_pi || req_init);
      m_pw = (g == 2) ? 1'b0 : (m_pw || req_write);
      m_pr = (!read_en || g == 3) ? 1'b0 : (m_pr || tk);
      m_run = read_en ? m_run + 1 : 0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [10:0] exp_v, act_v;
    logic [3:0] bus;
    bit in_txn, in_gap;
    cycle_no++;
    act_v = {a_d, cs, rd, wr, do_it_init, do_it_escribir, do_it_leer, busy, grant, done};
    if (!reset) begin
      exp_v = {4'hF, 3'b000, 1'b0, 2'b00, 1'b0};
    end else begin
      in_txn = (m_cur != 0) && (m_t < len_of(m_cur));
      in_gap = (m_cur != 0) && (m_t >= len_of(m_cur));
      bus = 4'hF;
      if (in_txn && m_cur == 1) bus = {init_a_d, init_cs, init_rd, init_wr};
      if (in_txn && m_cur == 2) bus = {wr_a_d, wr_cs, wr_rd, wr_wr};
      if (in_txn && m_cur == 3) bus = {rd_a_d, rd_cs, rd_rd, rd_wr};
      exp_v = {bus, in_txn && m_cur == 1, in_txn && m_cur == 2, in_txn && m_cur == 3,
               m_cur != 0, in_txn ? 2'(m_cur) : 2'b00,
               in_gap && (m_t == len_of(m_cur))};
    end
    chk("cycle_outputs", 32'(act_v), 32'(exp_v));
  end

  // One clock: randomize bus inputs after the edge, return at the falling edge
  task automatic cyc();
    @(posedge clk);
    #2;
    {init_a_d, init_cs, init_rd, init_wr, wr_a_d, wr_cs, wr_rd, wr_wr,
     rd_a_d, rd_cs, rd_rd, rd_wr} = 12'($urandom);
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, k, n, t, last, nonzero;
    int q[$];
    int rises[$];
    logic [1:0] pg;

    repeat (3) cyc();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bus", 32'({a_d, cs, rd, wr}), 32'hF);
    #1 reset = 1'b1;
    repeat (3) cyc();

    // single-cycle write request, bus mux checks during WRITE and GAP
    req_write = 1'b1;
    cyc();
    req_write = 1'b0;
    chk("write_grant", 32'(grant), 32'd2);
    #1 wr_cs = 1'b0; rd_cs = 1'b1; init_cs = 1'b1;
    #1 chk("mux_wr_cs_0", 32'(cs), 32'd0);
    wr_cs = 1'b1; rd_cs = 1'b0; init_cs = 1'b0;
    #1 chk("mux_wr_cs_1", 32'(cs), 32'd1);
    hi = 1;
    for (int i = 0; i < 1000 && do_it_escribir; i++) begin cyc(); if (do_it_escribir) hi++; end
    chk("write_len", 32'(hi), 32'(NW));
    chk("write_done", 32'(done), 32'd1);
    #1 wr_cs = 1'b0;
    #1 chk("gap_cs_idle", 32'(cs), 32'd1);
    k = 1;
    for (int i = 0; i < 100 && busy; i++) begin cyc(); if (busy) k++; end
    chk("gap_len", 32'(k), 32'(G));
    chk("idle_grant", 32'(grant), 32'd0);

    // init, write and refresh tick on the same edge
    read_en = 1'b1;
    repeat (P - 1) cyc();
    req_init = 1'b1; req_write = 1'b1;
    cyc();
    req_init = 1'b0; req_write = 1'b0;
    n = 0; pg = 2'b00;
    for (int i = 0; i < 3000 && n < 3; i++) begin
      if (grant != 2'b00 && grant != pg) q.push_back(int'(grant));
      pg = grant;
      if (done) n++;
      if (n < 3) cyc();
    end
    chk("order_count", 32'(q.size()), 32'd3);
    if (q.size() == 3) begin
      chk("order_0", 32'(q[0]), 32'd1);
      chk("order_1", 32'(q[1]), 32'd2);
      chk("order_2", 32'(q[2]), 32'd3);
    end
    chk("order_dones", 32'(n), 32'd3);
    read_en = 1'b0;
    for (int i = 0; i < 100 && busy; i++) cyc();
    repeat (5) cyc();

    // periodic refresh reads, then init request and read_en drop mid-read
    read_en = 1'b1;
    t = 0; last = 0;
    for (int i = 0; i < 3500 && rises.size() < 3; i++) begin
      cyc(); t++;
      if (do_it_leer && !last) rises.push_back(t);
      last = do_it_leer;
    end
    chk("refresh_rises", 32'(rises.size()), 32'd3);
    if (rises.size() == 3) begin
      chk("refresh_period_a", 32'(rises[1] - rises[0]), 32'(P));
      chk("refresh_period_b", 32'(rises[2] - rises[1]), 32'(P));
    end
    hi = 1;
    repeat (50) begin cyc(); if (do_it_leer) hi++; end
    req_init = 1'b1; read_en = 1'b0;
    cyc(); if (do_it_leer) hi++;
    req_init = 1'b0;
    chk("no_preempt", 32'(do_it_init), 32'd0);
    for (int i = 0; i < 1000 && do_it_leer; i++) begin cyc(); if (do_it_leer) hi++; end
    chk("read_len", 32'(hi), 32'(NR));
    k = 0;
    for (int i = 0; i < 100 && !do_it_init; i++) begin cyc(); k++; end
    chk("init_after_gap", 32'(k), 32'(G + 1));
    n = 0;
    repeat (2500) begin cyc(); if (do_it_leer) n++; end
    chk("no_reads_after_disable", 32'(n), 32'd0);

    // randomized traffic with one mid-run reset
    read_en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      req_init = ($urandom_range(0, 399) == 0);
      req_write = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1999) == 0) read_en = ~read_en;
      if (i == 7000) begin
        #1 reset = 1'b0;
        cyc(); cyc();
        #1 reset = 1'b1;
      end
      cyc();
    end
    req_init = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 1000 && busy; i++) cyc();

    // reset asserted at read count 100
    read_en = 1'b1;
    for (int i = 0; i < 2 * P && !do_it_leer; i++) cyc();
    chk("read_seen_before_reset", 32'(do_it_leer), 32'd1);
    repeat (100) cyc();
    #1 reset = 1'b0;
    #1;
    chk("abort_do_it_leer", 32'(do_it_leer), 32'd0);
    chk("abort_bus", 32'({a_d, cs, rd, wr}), 32'hF);
    chk("abort_grant", 32'(grant), 32'd0);
    read_en = 1'b0;
    cyc();
    #1 reset = 1'b1;
    nonzero = 0;
    repeat (20) begin cyc(); if (grant != 2'b00 || busy) nonzero++; end
    chk("post_reset_quiet", 32'(nonzero), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
